// File: rtl/sha256_arbiter.sv
// Round-robin arbiter sharing one sha256 core among NUM_REQ requesters, one transaction at a time.
// Optional WAIT-state watchdog is compiled in when SHA_ARB_TIMEOUT_EN is defined.
module sha256_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_v_i,
    input  logic [512*NUM_REQ-1:0]     req_data_i,
    output logic [NUM_REQ-1:0]         req_r_o,
    output logic [NUM_REQ-1:0]         resp_v_o,
    output logic [255:0]               resp_data_o,
    input  logic [NUM_REQ-1:0]         resp_r_i,
    output logic                       core_in_valid_o,
    output logic [511:0]               core_in_o,
    input  logic                       core_in_ready_i,
    input  logic                       core_out_valid_i,
    input  logic [255:0]               core_out_i,
    output logic                       core_out_ready_o,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_o,
    output logic                       timeout_o
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic [255:0]  result_q, result_d;

`ifdef SHA_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    // Scan downward so the nearest requester after 'last' is the one left in 'pick'.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [GW-1:0]      last);
        logic [GW-1:0] pick;
        logic [GW-1:0] cand;
        int            idx;
        pick = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx  = (int'(last) + k) % NUM_REQ;
            cand = GW'(idx);
            if (v[cand]) pick = cand;
        end
        return pick;
    endfunction

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        last_d           = last_q;
        result_d         = result_q;
        req_r_o          = '0;
        resp_v_o         = '0;
        core_in_valid_o  = 1'b0;
        core_in_o        = '0;
        core_out_ready_o = 1'b0;
`ifdef SHA_ARB_TIMEOUT_EN
        cnt_d            = cnt_q;
        tmo_d            = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req_v_i) begin
                    grant_d = rr_pick(req_v_i, last_q);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                core_in_valid_o  = 1'b1;
                core_in_o        = req_data_i[32'(grant_q) * 512 +: 512];
                req_r_o[grant_q] = core_in_ready_i;
                if (core_in_ready_i) begin
                    state_d = WAIT;
`ifdef SHA_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT: begin
                core_out_ready_o = 1'b1;
                if (core_out_valid_i) begin
                    result_d = core_out_i;
                    state_d  = RESP;
                end
`ifdef SHA_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_d   = 1'b1;
                    last_d  = grant_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                resp_v_o[grant_q] = 1'b1;
                if (resp_r_i[grant_q]) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset leaves requester 0 as the first in line.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= GW'(NUM_REQ - 1);
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            result_q <= result_d;
        end
    end

`ifdef SHA_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
    assign timeout_o = tmo_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign busy_o      = (state_q != IDLE);
    assign grant_o     = grant_q;
    assign resp_data_o = result_q;

endmodule

// File: tb/tb_sha256_arbiter.sv
// Self-checking bench for sha256_arbiter (default build, NUM_REQ=4): directed table,
// hand-written reset/corner sequences and randomized transactions against a round-robin model.
module tb_sha256_arbiter;

    localparam int NR = 4;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [NR-1:0]   req_v_i;
    logic [512*NR-1:0] req_data_i;
    logic [NR-1:0]   req_r_o;
    logic [NR-1:0]   resp_v_o;
    logic [255:0]    resp_data_o;
    logic [NR-1:0]   resp_r_i;
    logic            core_in_valid_o;
    logic [511:0]    core_in_o;
    logic            core_in_ready_i;
    logic            core_out_valid_i;
    logic [255:0]    core_out_i;
    logic            core_out_ready_o;
    logic            busy_o;
    logic [1:0]      grant_o;
    logic            timeout_o;

    sha256_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_v_i(req_v_i), .req_data_i(req_data_i), .req_r_o(req_r_o),
        .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_r_i(resp_r_i),
        .core_in_valid_o(core_in_valid_o), .core_in_o(core_in_o), .core_in_ready_i(core_in_ready_i),
        .core_out_valid_i(core_out_valid_i), .core_out_i(core_out_i), .core_out_ready_o(core_out_ready_o),
        .busy_o(busy_o), .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int model_last = NR - 1;
    logic [511:0] blk [NR];
    logic [511:0] abc_blk;
    localparam logic [255:0] ABC_DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    typedef struct {
        logic [3:0] mask;
        int         exp_g;
        int         in_stall;
        int         out_dly;
        int         resp_stall;
    } vec_t;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: first pending requester strictly after the last served one, wrapping around.
    function automatic int model_pick(input logic [3:0] m);
        int order[$];
        for (int k = 1; k <= NR; k++) order.push_back((model_last + k) % NR);
        foreach (order[i]) if (m[order[i]]) return order[i];
        return -1;
    endfunction

    // Stand-in for the sha256 core: real digest for "abc", an arbitrary fold otherwise.
    function automatic logic [255:0] core_fn(input logic [511:0] b);
        if (b == abc_blk) return ABC_DIG;
        return b[511:256] ^ b[255:0] ^ 256'h5a5a;
    endfunction

    function automatic logic [255:0] junk256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic load_blocks(input bit use_abc);
        for (int r = 0; r < NR; r++) begin
            blk[r] = {junk256(), junk256()};
            req_data_i[r*512 +: 512] = blk[r];
        end
        if (use_abc) begin
            blk[0] = abc_blk;
            req_data_i[511:0] = abc_blk;
        end
    endtask

    task automatic do_reset();
        req_v_i = '0; resp_r_i = '0; core_in_ready_i = 1'b0; core_out_valid_i = 1'b0;
        rst_i = 1'b0;
        tick(); tick();
        rst_i = 1'b1;
        model_last = NR - 1;
    endtask

    // One complete transaction; starts and ends at edge+1 of a cycle where the DUT is idle.
    task automatic txn(input logic [3:0] mask, input int exp_tbl, input int in_stall,
                       input int out_dly, input int resp_stall, input bit use_abc);
        int g;
        logic [255:0] dig;
        logic [3:0] oh;
        g = (exp_tbl >= 0) ? exp_tbl : model_pick(mask);
        oh = 4'(1 << g);
        load_blocks(use_abc);
        dig = core_fn(blk[g]);
        req_v_i = mask;
        tick();
        for (int i = 0; i <= in_stall; i++) begin
            core_in_ready_i = (i == in_stall);
            #1;
            if (i == 0) chk("grant", 512'(grant_o), 512'(g));
            chk("in_valid", 512'(core_in_valid_o), 512'(1));
            chk("req_r", 512'(req_r_o), (i == in_stall) ? 512'(oh) : 512'(0));
            chk("core_in", core_in_o, blk[g]);
            tick();
        end
        core_in_ready_i = 1'b0;
        req_v_i[g] = 1'b0;
        for (int i = 0; i <= out_dly; i++) begin
            core_out_valid_i = (i == out_dly);
            core_out_i = (i == out_dly) ? dig : junk256();
            #1;
            chk("wait_ready", 512'(core_out_ready_o), 512'(1));
            chk("wait_no_issue", 512'(core_in_valid_o), 512'(0));
            tick();
        end
        core_out_valid_i = 1'b0;
        core_out_i = junk256();
        for (int i = 0; i <= resp_stall; i++) begin
            resp_r_i = (i == resp_stall) ? 4'hf : ~oh;
            #1;
            chk("resp_v", 512'(resp_v_o), 512'(oh));
            chk("resp_data", 512'(resp_data_o), 512'(dig));
            chk("resp_no_issue", 512'(core_in_valid_o), 512'(0));
            tick();
        end
        resp_r_i = '0;
        model_last = g;
        #1;
        chk("idle_busy", 512'(busy_o), 512'(0));
        chk("hold_data", 512'(resp_data_o), 512'(dig));
    endtask

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{4'b1111, 0, 0, 0, 0};
        tbl[1]  = '{4'b1111, 1, 5, 2, 0};
        tbl[2]  = '{4'b1111, 2, 0, 1, 10};
        tbl[3]  = '{4'b1111, 3, 1, 0, 1};
        tbl[4]  = '{4'b1111, 0, 0, 3, 0};
        tbl[5]  = '{4'b1111, 1, 2, 0, 2};
        tbl[6]  = '{4'b1111, 2, 0, 0, 0};
        tbl[7]  = '{4'b1111, 3, 0, 1, 0};
        tbl[8]  = '{4'b0100, 2, 1, 1, 1};
        tbl[9]  = '{4'b1001, 3, 0, 0, 0};
        tbl[10] = '{4'b0011, 0, 0, 2, 0};
        tbl[11] = '{4'b0110, 1, 0, 0, 3};
        tbl[12] = '{4'b1010, 3, 2, 0, 0};
        tbl[13] = '{4'b0001, 0, 0, 0, 0};

        abc_blk = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[7:0] = 8'h18;
        req_data_i = '0; core_out_i = '0;
        req_v_i = '0; resp_r_i = '0; core_in_ready_i = 1'b0; core_out_valid_i = 1'b0;
        rst_i = 1'b0;
        #2;
        chk("rst_busy", 512'(busy_o), 512'(0));
        chk("rst_grant", 512'(grant_o), 512'(0));
        chk("rst_resp_data", 512'(resp_data_o), 512'(0));
        chk("rst_in_valid", 512'(core_in_valid_o), 512'(0));
        chk("rst_timeout", 512'(timeout_o), 512'(0));
        do_reset();

        // Single "abc" block from requester 0.
        txn(4'b0001, 0, 0, 2, 0, 1'b1);

        // Table: round-robin from reset, then assorted masks, stalls and backpressure.
        do_reset();
        for (int i = 0; i < 14; i++)
            txn(tbl[i].mask, tbl[i].exp_g, tbl[i].in_stall, tbl[i].out_dly, tbl[i].resp_stall, 1'b0);

        // Reset while waiting on the core, then requesters 0 and 3 compete.
        load_blocks(1'b0);
        req_v_i = 4'b0010;
        tick();
        core_in_ready_i = 1'b1;
        tick();
        core_in_ready_i = 1'b0;
        req_v_i = '0;
        #1;
        chk("midwait_ready", 512'(core_out_ready_o), 512'(1));
        rst_i = 1'b0;
        core_out_valid_i = 1'b1;
        core_out_i = junk256();
        #1;
        chk("arst_busy", 512'(busy_o), 512'(0));
        chk("arst_ready", 512'(core_out_ready_o), 512'(0));
        chk("arst_outs", 512'({req_r_o, resp_v_o, core_in_valid_o, grant_o, timeout_o}), 512'(0));
        chk("arst_data", 512'(resp_data_o), 512'(0));
        chk("arst_core_in", core_in_o, 512'(0));
        tick();
        rst_i = 1'b1;
        model_last = NR - 1;
        #1;
        chk("post_rst_ready", 512'(core_out_ready_o), 512'(0));
        core_out_valid_i = 1'b0;
        txn(4'b1001, 0, 0, 0, 0, 1'b0);

        // Randomized traffic against the round-robin model.
        for (int n = 0; n < 40; n++)
            txn(4'($urandom_range(1, 15)), -1, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'b0);

        req_v_i = '0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha256_arbiter.md
SHA256_ARBITER -- requirements
Module: sha256_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one sha256 core (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, watchdog limit in cycles; used only when SHA_ARB_TIMEOUT_EN is defined.
REQ-003 Port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 Port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 Port req_v_i  input  NUM_REQ  per-requester block-valid.
REQ-006 Port req_data_i  input  512*NUM_REQ  per-requester 512-bit block; requester r uses bits [512r+511:512r].
REQ-007 Port req_r_o  output  NUM_REQ  per-requester block-accepted.
REQ-008 Port resp_v_o  output  NUM_REQ  per-requester digest-valid.
REQ-009 Port resp_data_o  output  256  digest, shared by all requesters.
REQ-010 Port resp_r_i  input  NUM_REQ  per-requester digest-ready.
REQ-011 Ports core_in_valid_o (out 1), core_in_o (out 512), core_in_ready_i (in 1): block handshake to the sha256 core.
REQ-012 Ports core_out_valid_i (in 1), core_out_i (in 256), core_out_ready_o (out 1): digest handshake from the sha256 core.
REQ-013 Port busy_o  output  1  high in any state except IDLE.
REQ-014 Port grant_o  output  $clog2(NUM_REQ)  index of the current or most recent grantee.
REQ-015 Port timeout_o  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP; exactly one transaction outstanding at a time.
REQ-017 IDLE: if any req_v_i bit is set, grant the first set bit searching round-robin from last_grant+1 (mod NUM_REQ), register it in grant_o, and go to ISSUE; otherwise stay in IDLE.
REQ-018 ISSUE: core_in_valid_o=1; core_in_o=req_data_i slice of grantee; req_r_o[grant]=core_in_ready_i; all other req_r_o bits are 0.
REQ-019 ISSUE: advance to WAIT on the cycle where core_in_valid_o and core_in_ready_i are both 1.
REQ-020 Requesters hold req_v_i and data stable from assertion until req_r_o is seen; the arbiter does not latch block data.
REQ-021 WAIT: core_out_ready_o=1; when core_out_valid_i=1, latch core_out_i into the result register and go to RESP.
REQ-022 core_out_ready_o is 0 outside WAIT, so core output in other states is neither consumed nor stored.
REQ-023 RESP: resp_v_o[grant]=1, other bits 0; resp_data_o=result register.
REQ-024 RESP: when resp_r_i[grant]=1, set last_grant=grant and go to IDLE.
REQ-025 Minimum latency: req_v_i rise to core_in_valid_o is 1 cycle; core_out_valid_i to resp_v_o is 1 cycle; RESP to next ISSUE is 2 cycles.
REQ-026 Fairness: a continuously asserting requester is granted within NUM_REQ transactions.
REQ-027 A request arriving during ISSUE, WAIT or RESP waits and is not granted until the next IDLE.
REQ-028 resp_data_o holds its last value outside RESP.

Reset
REQ-029 Reset asserted (rst_i=0), including mid-transaction, immediately forces: state=IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority), grant_o=0, result=0.
REQ-030 Reset also forces all outputs to 0; an in-flight core transaction is abandoned and the core is reset by the same rst_i.

Configuration
REQ-031 Macro SHA_ARB_TIMEOUT_EN defined: a counter clears on entry to WAIT and increments each WAIT cycle.
REQ-032 With SHA_ARB_TIMEOUT_EN defined: at count TIMEOUT_CYCLES-1 without core_out_valid_i, pulse timeout_o for one cycle, return to IDLE without a response, and set last_grant=grant.
REQ-033 Macro SHA_ARB_TIMEOUT_EN undefined: no counter exists, timeout_o is tied to 0, and WAIT is left only on core_out_valid_i.

Verification
REQ-034 Single request: requester 0 sends the padded "abc" block 0x6162638000...0018 -> resp_v_o[0]=1 with resp_data_o=0xba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-035 Round-robin: all 4 req_v_i held high for 8 transactions -> grant_o sequence 0,1,2,3,0,1,2,3.
REQ-036 Backpressure: resp_r_i[2]=0 for 10 cycles in RESP -> resp_v_o[2] and resp_data_o stay stable, no new ISSUE occurs, and the transaction completes on resp_r_i[2]=1.
REQ-037 Core stall: core_in_ready_i=0 for 5 cycles in ISSUE -> core_in_valid_o stays 1, req_r_o stays 0, and the transfer happens on the 6th cycle.
REQ-038 Reset mid-WAIT: rst_i=0 for 1 cycle -> all outputs 0 and state IDLE; a following request from requester 3 with requester 0 also pending -> grant_o=0.
REQ-039 With SHA_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: core never returns -> timeout_o pulses 16 cycles after WAIT entry, then the next pending requester is granted.
